ifu_fetch: RTL

//   Instruction fetch unit: the initiator side of the instruction-memory port.

---
 rtl/ifu_fetch.sv | 79 +++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, drives the combinational instruction memory
// and presents {instr, pc} to decode through a valid/ready IF/ID register.
module ifu_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imaddr,
  input  logic [31:0] instr,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc8,
  output logic        fetch_err
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [31:0] IM_BYTES = 32'(4 * IM_WORDS);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_off;
  logic        pc_ok;
  logic        advance;

  // Subtracting the base first means a pc below IM_BASE wraps to a huge offset;
  // the explicit lower-bound test keeps that case illegal as well.
  assign pc_off  = pc - IM_BASE;
  assign imaddr  = pc_off;
  assign pc_ok   = (pc[1:0] == 2'b00) && (pc >= IM_BASE) && (pc_off < IM_BYTES);
  assign advance = (state == RUN) && (!out_valid || out_ready);
  assign out_pc8 = out_pc + 32'd8;

  // NOTE: all state updates use non-blocking assignments so every register in this
  // block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pc        <= PC_RESET;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (redirect_en) begin
            // Flush the wrong-path fetch; a held instruction with out_ready=1
            // has already been consumed by decode this cycle.
            pc        <= redirect_pc;
            out_valid <= 1'b0;
          end else if (advance && !pc_ok) begin
            state     <= HALT;
            fetch_err <= 1'b1;
            out_valid <= 1'b0;
          end else if (advance) begin
            out_instr <= instr;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + 32'd4;
          end
        end
        HALT: begin
          out_valid <= 1'b0;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule
